// File: rtl/ptr_sync_gray_pkg.sv
// Shared constants, types and gray/binary helpers for the gray-pointer
// synchroniser. Helpers operate on a fixed wide word; callers zero-extend
// narrower pointers in and truncate the result back, which is exact for
// gray/binary conversion because leading zero bits do not alter lower bits.
package ptr_sync_pkg;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;

  // Widest pointer the helper functions handle.
  localparam int PTR_MAX_W = 32;

  // Width of the warm-up counter; holds up to STAGES_MAX+1.
  localparam int WU_W = 3;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  // Width of a population count over a ptr_word_t (0..32).
  typedef logic [5:0] pop_t;

  // What the error tracker does on a given cycle.
  typedef enum logic [1:0] {
    ERR_HOLD    = 2'd0,
    ERR_CLEAR   = 2'd1,
    ERR_HIT     = 2'd2,
    ERR_HIT_CLR = 2'd3
  } err_action_t;

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to gray: adjacent binary values differ in exactly one gray bit.
  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Number of set bits; used to spot gray steps that flip more than one bit.
  function automatic pop_t popcount(input ptr_word_t w);
    pop_t c;
    c = '0;
    for (int i = 0; i < PTR_MAX_W; i++) begin
      c = c + {5'b0, w[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ptr_sync_gray_if.sv
// Bundle of the synchroniser's data and status signals. The master side
// supplies the foreign gray pointer and error clear; the slave side (the
// synchroniser) returns the synchronised pointer and its derived status.
interface ptr_sync_gray_if #(
  parameter int ADDRSIZE = 4,
  parameter int ERRW     = 8
);

  logic [ADDRSIZE:0] graycode_wptr;
  logic              err_clr;
  logic [ADDRSIZE:0] sync_gray;
  logic [ADDRSIZE:0] sync_bin;
  logic [ADDRSIZE:0] ptr_delta;
  logic              ptr_moved;
  logic              sync_valid;
  logic              err_multibit;
  logic [ERRW-1:0]   err_cnt;

  modport master (
    output graycode_wptr,
    output err_clr,
    input  sync_gray,
    input  sync_bin,
    input  ptr_delta,
    input  ptr_moved,
    input  sync_valid,
    input  err_multibit,
    input  err_cnt
  );

  modport slave (
    input  graycode_wptr,
    input  err_clr,
    output sync_gray,
    output sync_bin,
    output ptr_delta,
    output ptr_moved,
    output sync_valid,
    output err_multibit,
    output err_cnt
  );

endinterface

// File: rtl/ptr_sync_gray_sync_chain.sv
// Bare multi-flop synchroniser chain. Kept in its own module with nothing
// but flops between d and q so CDC constraints can target it by name.
module sync_chain #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             rclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s [1:STAGES];

  // Shift the foreign value one flop further each receiving-clock edge.
  always_ff @(posedge rclk) begin
    if (rst) begin
      for (int i = 1; i <= STAGES; i++) begin
        s[i] <= '0;
      end
    end else begin
      s[1] <= d;
      for (int i = 2; i <= STAGES; i++) begin
        s[i] <= s[i-1];
      end
    end
  end

  assign q = s[STAGES];

endmodule

// File: rtl/ptr_sync_gray.sv
// Gray-pointer synchroniser for the async FIFO. Brings a foreign-domain gray
// pointer across through sync_chain, then in the receiving domain converts
// it to binary, reports the per-cycle advance, masks start-up garbage with a
// warm-up window and tracks illegal multi-bit gray steps.
module ptr_sync_gray
  import ptr_sync_pkg::*;
#(
  parameter int ADDRSIZE = 4,
  parameter int STAGES   = 2,
  parameter int ERRW     = 8
) (
  input logic          rclk,
  input logic          rst,
  ptr_sync_gray_if.slave bus
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [WU_W-1:0] WU_END = WU_W'(STAGES + 1);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("ptr_sync_gray: STAGES=%0d outside legal range %0d..%0d",
           STAGES, STAGES_MIN, STAGES_MAX);
  end

  if (PW > PTR_MAX_W) begin : g_bad_width
    $error("ptr_sync_gray: pointer width %0d exceeds %0d", PW, PTR_MAX_W);
  end

  logic [PW-1:0]   sync_gray;
  logic [PW-1:0]   g_prev;
  logic [PW-1:0]   sync_bin;
  logic [PW-1:0]   ptr_delta;
  logic            ptr_moved;
  logic            sync_valid;
  logic            err_multibit;
  logic [ERRW-1:0] err_cnt;
  logic [WU_W-1:0] wu;

  logic [PW-1:0]   cur_bin;
  logic [PW-1:0]   delta_next;
  logic            hit;
  logic            err_sat;
  logic [WU_W-1:0] wu_next;
  err_action_t     err_action;

  sync_chain #(
    .WIDTH  (PW),
    .STAGES (STAGES)
  ) u_sync_chain (
    .rclk (rclk),
    .rst  (rst),
    .d    (bus.graycode_wptr),
    .q    (sync_gray)
  );

  // Derive binary value, modular advance, multi-bit check and warm-up step.
  always_comb begin
    cur_bin    = PW'(gray2bin(PTR_MAX_W'(sync_gray)));
    delta_next = cur_bin - sync_bin;
    hit        = sync_valid && (popcount(PTR_MAX_W'(sync_gray ^ g_prev)) > 6'd1);
    err_sat    = &err_cnt;
    wu_next    = (wu == WU_END) ? wu : wu + 1'b1;
  end

  // Choose the error tracker action; a hit on the same cycle as a clear wins.
  always_comb begin
    err_action = ERR_HOLD;
    if (hit && bus.err_clr) begin
      err_action = ERR_HIT_CLR;
    end else if (hit) begin
      err_action = ERR_HIT;
    end else if (bus.err_clr) begin
      err_action = ERR_CLEAR;
    end
  end

  // Count edges out of reset and open the valid window after the chain fills.
  always_ff @(posedge rclk) begin
    if (rst) begin
      wu         <= '0;
      sync_valid <= 1'b0;
    end else begin
      wu <= wu_next;
      if (wu_next == WU_END) begin
        sync_valid <= 1'b1;
      end
    end
  end

  // Register the binary pointer and its advance; advance is forced to zero
  // until the chain holds a trustworthy value.
  always_ff @(posedge rclk) begin
    if (rst) begin
      g_prev    <= '0;
      sync_bin  <= '0;
      ptr_delta <= '0;
      ptr_moved <= 1'b0;
    end else begin
      g_prev   <= sync_gray;
      sync_bin <= cur_bin;
      if (sync_valid) begin
        ptr_delta <= delta_next;
        ptr_moved <= (delta_next != '0);
      end else begin
        ptr_delta <= '0;
        ptr_moved <= 1'b0;
      end
    end
  end

  // Sticky multi-bit flag and saturating event counter.
  always_ff @(posedge rclk) begin
    if (rst) begin
      err_multibit <= 1'b0;
      err_cnt      <= '0;
    end else begin
      case (err_action)
        ERR_HIT_CLR: begin
          err_multibit <= 1'b1;
          err_cnt      <= ERRW'(1);
        end
        ERR_HIT: begin
          err_multibit <= 1'b1;
          if (!err_sat) begin
            err_cnt <= err_cnt + 1'b1;
          end
        end
        ERR_CLEAR: begin
          err_multibit <= 1'b0;
          err_cnt      <= '0;
        end
        default: begin
          err_multibit <= err_multibit;
          err_cnt      <= err_cnt;
        end
      endcase
    end
  end

  assign bus.sync_gray    = sync_gray;
  assign bus.sync_bin     = sync_bin;
  assign bus.ptr_delta    = ptr_delta;
  assign bus.ptr_moved    = ptr_moved;
  assign bus.sync_valid   = sync_valid;
  assign bus.err_multibit = err_multibit;
  assign bus.err_cnt      = err_cnt;

endmodule

// File: doc/ptr_sync_gray.md
# ptr_sync_gray

Parametrised gray-pointer clock-domain-crossing synchroniser for the async FIFO, successor to the fixed two-flop write-to-read pointer sync. It samples a gray-coded pointer from the foreign domain through a configurable-depth flop chain, converts it to binary, reports the per-cycle pointer advance, and flags illegal multi-bit gray transitions. It sits in the receiving domain (read side for the write pointer, or vice versa) and feeds the full/empty logic.

## Interface
- ADDRSIZE, 4: FIFO address bits; pointer width is ADDRSIZE+1.
- STAGES, 2: synchroniser depth, legal range 2..4; elaboration error outside range.
- ERRW, 8: width of saturating error counter.

- rclk  in  1  receiving-domain clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- graycode_wptr  in  ADDRSIZE+1  gray pointer from foreign domain (asynchronous to rclk).
- err_clr  in  1  clears err_multibit and err_cnt.
- sync_gray  out  ADDRSIZE+1  synchronised gray pointer.
- sync_bin  out  ADDRSIZE+1  binary of sync_gray, registered.
- ptr_delta  out  ADDRSIZE+1  binary advance since previous cycle, mod 2^(ADDRSIZE+1).
- ptr_moved  out  1  ptr_delta != 0.
- sync_valid  out  1  warm-up complete, outputs trustworthy.
- err_multibit  out  1  sticky: sync_gray changed in more than one bit in one cycle.
- err_cnt  out  ERRW  count of multi-bit events, saturating at all-ones.

## Operation
- Chain s[1..STAGES]: s[1] <= graycode_wptr, s[i] <= s[i-1]; sync_gray = s[STAGES]. No logic between chain flops.
- g_prev <= sync_gray each cycle.
- sync_bin <= gray2bin(sync_gray); ptr_delta <= gray2bin(sync_gray) - sync_bin (mod 2^(ADDRSIZE+1)) when sync_valid, else 0; ptr_moved <= same condition with delta != 0.
- Multi-bit check: hit = sync_valid && popcount(sync_gray ^ g_prev) > 1. On hit: err_multibit <= 1, err_cnt <= err_cnt+1 unless saturated.
- err_clr: err_multibit <= 0, err_cnt <= 0. Simultaneous hit and err_clr: hit wins, err_multibit=1, err_cnt=1.
- Warm-up: counter wu counts rclk edges with rst low, stops at STAGES+1; sync_valid registered, rises on edge where wu reaches STAGES+1.
- Wrap-around: gray 10000 -> 00000 (ADDRSIZE=4) is a one-bit change, no error; delta computed modulo, e.g. bin 31 -> 0 gives delta 1.

## Timing
- Reset: all chain flops, g_prev, sync_gray, sync_bin, ptr_delta, ptr_moved, sync_valid, err_multibit, err_cnt, wu = 0 after the edge sampling rst=1.
- Reset mid-operation: same; foreign pointer not reset, so first samples after release may jump — masked by warm-up (no error, delta 0).
- Latency input -> sync_gray: STAGES edges. Input -> sync_bin/ptr_delta/ptr_moved: STAGES+1 edges.
- sync_valid: 0 for first STAGES+1 edges after rst release, 1 from then until next reset.
- err_multibit/err_cnt update one edge after offending sync_gray value appears.
- err_clr takes effect at the next edge.

## Structure
- Package ptr_sync_pkg: functions gray2bin, bin2gray, popcount; STAGES_MIN/STAGES_MAX constants.
- Sub-module sync_chain (parameters WIDTH, STAGES; ports rclk, rst, d, q) holding only the flop chain, for CDC tool constraints.
- Top holds conversion, delta, check, warm-up and error logic.

## Test plan
- Reset/warm-up, STAGES=2: rst 3 cycles, input 00000 -> all outputs 0; sync_valid rises exactly 3 edges after release.
- Latency: after warm-up, step input gray 00000 -> 00001 -> sync_gray 00001 after 2 edges, sync_bin 1, ptr_delta 1, ptr_moved 1 one edge later, then delta 0.
- Wrap: ramp pointer 0..31 then 0 (gray), one step per 3 cycles -> no error, delta 1 at 31->0.
- Illegal jump: input 00000 -> 00011 -> err_multibit 1, err_cnt 1; repeat 300 events, ERRW=8 -> err_cnt holds 255.
- err_clr collision: assert err_clr on same edge as hit -> err_multibit 1, err_cnt 1; err_clr alone -> both 0.
- Reset mid-run with input held at 10110: no error, ptr_delta 0 during warm-up, sync_bin 11011 (27) at sync_valid rise; repeat with STAGES=3, 4 (sync_valid rises at edges 4, 5).
